// File: rtl/vga_flash_pkg.sv
// Shared types and constants for the VGA-side flash read responder.
// FLASH_READ_ARRAY_CMD_EN adds a one-shot Read Array command after power-up.
package vga_flash_pkg;

  localparam int DEF_ADDR_W = 23;
  localparam int DEF_DATA_W = 16;
  localparam logic [15:0] FLASH_CMD_READ_ARRAY = 16'h00FF;

  typedef enum logic [2:0] {
    ST_POWERUP,
`ifdef FLASH_READ_ARRAY_CMD_EN
    ST_CMD,
    ST_CMD_REC,
`endif
    ST_IDLE,
    ST_SETUP,
    ST_WAIT,
    ST_RESP,
    ST_GAP
  } state_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/flash_wait_counter.sv
// Loadable down-counter that stops at zero; done flags the last cycle of a timed state.
module flash_wait_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_load)             r_cnt <= i_val;
    else if (r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/vga_flash_responder.sv
// Serves VGA loader word reads with single asynchronous NOR flash read cycles.
// FLASH_READ_ARRAY_CMD_EN enables the post-power-up Read Array command write.
module vga_flash_responder
  import vga_flash_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = 6,
  parameter int HOLD_CYCLES = 3,
  parameter int PWR_CYCLES  = 8,
  parameter int CMD_CYCLES  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_re,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_success,
  output logic              busy,
  output logic [ADDR_W-1:0] flash_a,
  inout  wire  [DATA_W-1:0] flash_d,
  output logic              flash_ce_n,
  output logic              flash_oe_n,
  output logic              flash_we_n,
  output logic              flash_byte_n,
  output logic              flash_rp_n,
  output logic              flash_vpen
);

  localparam int CNT_MAX = max4(WAIT_CYCLES, HOLD_CYCLES, PWR_CYCLES, CMD_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t             r_state, w_nxt;
  logic               w_load;
  logic [CNT_W-1:0]   w_load_val;
  logic               w_done;
  logic               w_ce;

  logic [DATA_W-1:0]  r_data;
  logic               r_success;
  logic               r_busy;
  logic [ADDR_W-1:0]  r_flash_a;
  logic               r_ce_n;
  logic               r_oe_n;
  logic               r_rp_n;

  flash_wait_counter #(.W(CNT_W)) u_cnt (
    .clk    (clk),
    .i_load (w_load),
    .i_val  (w_load_val),
    .o_done (w_done)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_POWERUP;
    else     r_state <= w_nxt;
  end

  // Counter reloads on entry to each timed state; reset preloads the power-up wait
  // with the full count so busy stays high for PWR_CYCLES after release.
  always_comb begin
    w_nxt      = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    if (rst) begin
      w_load     = 1'b1;
      w_load_val = CNT_W'(PWR_CYCLES);
    end else begin
      case (r_state)
        ST_POWERUP: if (w_done) begin
`ifdef FLASH_READ_ARRAY_CMD_EN
          w_nxt      = ST_CMD;
          w_load     = 1'b1;
          w_load_val = CNT_W'(CMD_CYCLES - 1);
`else
          w_nxt      = ST_IDLE;
`endif
        end
`ifdef FLASH_READ_ARRAY_CMD_EN
        ST_CMD:     if (w_done) w_nxt = ST_CMD_REC;
        ST_CMD_REC: w_nxt = ST_IDLE;
`endif
        ST_IDLE:    if (vga_re) w_nxt = ST_SETUP;
        ST_SETUP: begin
          w_nxt      = ST_WAIT;
          w_load     = 1'b1;
          w_load_val = CNT_W'(WAIT_CYCLES - 1);
        end
        ST_WAIT: if (w_done) begin
          w_nxt      = ST_RESP;
          w_load     = 1'b1;
          w_load_val = CNT_W'(HOLD_CYCLES - 1);
        end
        ST_RESP:    if (w_done) w_nxt = ST_GAP;
        ST_GAP:     w_nxt = ST_IDLE;
        default:    w_nxt = ST_IDLE;
      endcase
    end
    w_ce = (w_nxt == ST_SETUP) || (w_nxt == ST_WAIT);
`ifdef FLASH_READ_ARRAY_CMD_EN
    if (w_nxt == ST_CMD) w_ce = 1'b1;
`endif
  end

  // Outputs are registered from the next state so pins track the state occupied.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data    <= '0;
      r_success <= 1'b0;
      r_busy    <= 1'b0;
      r_flash_a <= '0;
      r_ce_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_rp_n    <= 1'b0;
    end else begin
      r_busy    <= (w_nxt != ST_IDLE);
      r_rp_n    <= 1'b1;
      r_ce_n    <= !w_ce;
      r_oe_n    <= (w_nxt != ST_WAIT);
      r_success <= (w_nxt == ST_RESP);
      if (r_state == ST_IDLE && vga_re)
        r_flash_a <= vga_addr & ~ADDR_W'(1);
      if (r_state == ST_WAIT && w_done)
        r_data <= flash_d;
`ifdef FLASH_READ_ARRAY_CMD_EN
      if (w_nxt == ST_CMD)
        r_flash_a <= '0;
`endif
    end
  end

`ifdef FLASH_READ_ARRAY_CMD_EN
  logic r_we_n;
  logic r_d_oe;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we_n <= 1'b1;
      r_d_oe <= 1'b0;
    end else begin
      r_we_n <= (w_nxt != ST_CMD);
      r_d_oe <= (w_nxt == ST_CMD);
    end
  end

  assign flash_we_n = r_we_n;
  assign flash_d    = r_d_oe ? DATA_W'(FLASH_CMD_READ_ARRAY) : {DATA_W{1'bz}};
`else
  assign flash_we_n = 1'b1;
  assign flash_d    = {DATA_W{1'bz}};
`endif

  assign vga_data     = r_data;
  assign vga_success  = r_success;
  assign busy         = r_busy;
  assign flash_a      = r_flash_a;
  assign flash_ce_n   = r_ce_n;
  assign flash_oe_n   = r_oe_n;
  assign flash_rp_n   = r_rp_n;
  assign flash_byte_n = 1'b1;
  assign flash_vpen   = 1'b0;

endmodule

// File: tb/tb_vga_flash_responder.sv
// Directed bench for vga_flash_responder with a flash model and an expected-word queue.
module tb_vga_flash_responder;

  localparam int WAIT_CYCLES = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        vga_re;
  logic [22:0] vga_addr;
  logic [15:0] vga_data;
  logic        vga_success;
  logic        busy;
  logic [22:0] flash_a;
  wire  [15:0] flash_d;
  logic        flash_ce_n, flash_oe_n, flash_we_n, flash_byte_n, flash_rp_n, flash_vpen;

  int checks = 0;
  int failures = 0;
  int we_low_cnt = 0;
  int oe_cnt = 0;
  logic [15:0] sb[$];
  logic [15:0] zz = 16'hzzzz;

  vga_flash_responder dut (
    .clk(clk), .rst(rst), .vga_re(vga_re), .vga_addr(vga_addr),
    .vga_data(vga_data), .vga_success(vga_success), .busy(busy),
    .flash_a(flash_a), .flash_d(flash_d), .flash_ce_n(flash_ce_n),
    .flash_oe_n(flash_oe_n), .flash_we_n(flash_we_n), .flash_byte_n(flash_byte_n),
    .flash_rp_n(flash_rp_n), .flash_vpen(flash_vpen)
  );

  always #10 clk = ~clk;

  function automatic logic [15:0] model_word(input logic [22:0] a);
    if (a == 23'h10) return 16'hA55A;
    return a[15:0] ^ 16'h5C3A;
  endfunction

  // Flash model: data only becomes valid after the full access time has elapsed.
  always @(posedge clk) begin
    if (flash_oe_n) oe_cnt <= 0;
    else            oe_cnt <= oe_cnt + 1;
  end
  assign flash_d = (!flash_ce_n && !flash_oe_n) ?
                   ((oe_cnt >= WAIT_CYCLES - 1) ? model_word(flash_a) : 16'hDEAD) : 16'hzzzz;

  always @(negedge clk) if (flash_we_n !== 1'b1) we_low_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sb_pop();
    if (sb.size() == 0) return 16'hxxxx;
    return sb.pop_front();
  endfunction

  task automatic reset_checks(input string p);
    chk({p, "_data"}, vga_data, 0);
    chk({p, "_succ"}, vga_success, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_a"}, flash_a, 0);
    chk({p, "_ce"}, flash_ce_n, 1);
    chk({p, "_oe"}, flash_oe_n, 1);
    chk({p, "_we"}, flash_we_n, 1);
    chk({p, "_rp"}, flash_rp_n, 0);
    chk({p, "_d"}, flash_d, zz);
  endtask

  task automatic powerup_check();
    rst = 1'b0;
    step();
    chk("pwr_rp", flash_rp_n, 1);
    for (int i = 0; i < 8; i++) begin
      chk("pwr_busy", busy, 1);
      chk("pwr_ce", flash_ce_n, 1);
      step();
    end
`ifdef FLASH_READ_ARRAY_CMD_EN
    for (int i = 0; i < 4; i++) begin
      chk("cmd_we", flash_we_n, 0);
      chk("cmd_ce", flash_ce_n, 0);
      chk("cmd_a", flash_a, 0);
      chk("cmd_d", flash_d, 16'h00FF);
      step();
    end
    chk("cmdrec_we", flash_we_n, 1);
    chk("cmdrec_ce", flash_ce_n, 1);
    chk("cmdrec_d", flash_d, zz);
    chk("cmdrec_busy", busy, 1);
    step();
`endif
    chk("idle_busy", busy, 0);
    chk("idle_we", flash_we_n, 1);
  endtask

  task automatic do_read(input logic [22:0] addr, input logic [22:0] exp_a);
    logic [15:0] exp_d;
    vga_re = 1'b1;
    vga_addr = addr;
    sb.push_back(model_word(exp_a));
    step();
    chk("setup_a", flash_a, exp_a);
    chk("setup_ce", flash_ce_n, 0);
    chk("setup_oe", flash_oe_n, 1);
    vga_re = 1'b0;
    vga_addr = 23'h7FFFFE;
    for (int i = 0; i < WAIT_CYCLES; i++) begin
      step();
      chk("wait_oe", flash_oe_n, 0);
      chk("wait_ce", flash_ce_n, 0);
      chk("wait_succ", vga_success, 0);
    end
    step();
    exp_d = sb_pop();
    for (int i = 0; i < 3; i++) begin
      chk("resp_succ", vga_success, 1);
      chk("resp_data", vga_data, exp_d);
      chk("resp_ce", flash_ce_n, 1);
      step();
    end
    chk("gap_succ", vga_success, 0);
    chk("gap_data", vga_data, exp_d);
    chk("gap_busy", busy, 1);
    step();
    chk("post_idle", busy, 0);
  endtask

  initial begin
    logic [22:0] addr;
    int t;
    rst = 1'b1;
    vga_re = 1'b0;
    vga_addr = '0;
    repeat (5) step();
    reset_checks("rst");
    chk("byte_n", flash_byte_n, 1);
    chk("vpen", flash_vpen, 0);
    powerup_check();

    do_read(23'h000010, 23'h000010);
    do_read(23'h000013, 23'h000012);

    // Streaming requester: holds re high, advances address on the first success cycle.
    addr = '0;
    vga_addr = addr;
    sb.push_back(model_word(addr));
    vga_re = 1'b1;
    for (int k = 0; k < 32; k++) begin
      t = 0;
      while (!vga_success && t < 40) begin step(); t++; end
      chk("stream_timeout", vga_success, 1);
      if (k > 0) chk("stream_gap", t, 9);
      chk("stream_data", vga_data, sb_pop());
      if (k < 31) begin
        addr = addr + 23'd2;
        vga_addr = addr;
        sb.push_back(model_word(addr));
      end else begin
        vga_re = 1'b0;
      end
      t = 0;
      while (vga_success && t < 10) begin step(); t++; end
      chk("stream_hold", t, 3);
    end
    chk("stream_sb_empty", sb.size(), 0);
    step();

    // Reset during the third WAIT cycle aborts the read.
    vga_re = 1'b1;
    vga_addr = 23'h000020;
    step();
    vga_re = 1'b0;
    repeat (3) step();
    chk("midwait_oe", flash_oe_n, 0);
    rst = 1'b1;
    step();
    reset_checks("midrst");
    step();
    powerup_check();
    do_read(23'h000010, 23'h000010);

`ifdef FLASH_READ_ARRAY_CMD_EN
    chk("we_low_total", we_low_cnt, 8);
`else
    chk("we_low_total", we_low_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
